apb4_ram_ws: RTL and testbench

Parametrised APB4 slave RAM, the next generation of the team's single-cycle APB RAM. It adds:
- byte-lane write strobes (pstrb);
- a configurable number of wait states on pready;
- protection-checked writes (pprot) to an upper protected region;
- alignment and range error detection;
- a saturating error counter.

It sits behind the APB interconnect as a generic scratch/config memory for any peripheral subsystem.

---
 rtl/apb4_ram_ws.sv | 165 ++++++++++++++++
 tb/tb_apb4_ram_ws.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_ram_ws.sv
// APB4 slave RAM with byte strobes, configurable wait states, a protected upper region,
// alignment/range error detection and a saturating error counter.
module apb4_ram_ws #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PROT_BASE   = DEPTH,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [7:0]              err_cnt
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW = ADDR_WIDTH - LB;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);
  localparam logic [IW:0] PROT_W  = (IW+1)'(PROT_BASE);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] ERR_D = DATA_WIDTH'(ERR_DATA);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    latch_en;
  logic                    complete;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           strb_q;
  logic [2:0]              prot_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IW-1:0]           widx;
  logic [MW-1:0]           midx;
  logic                    misalign;
  logic                    out_of_range;
  logic                    prot_viol;
  logic                    err;
  logic                    unused_prot;

  assign widx = addr_q[ADDR_WIDTH-1:LB];
  assign midx = widx[MW-1:0];
  assign unused_prot = ^prot_q[2:1];

  // Sub-word address bits only exist when a word is wider than one byte
  if (LB > 0) begin : g_align
    assign misalign = |addr_q[LB-1:0];
  end else begin : g_noalign
    assign misalign = 1'b0;
  end

  assign out_of_range = {1'b0, widx} >= DEPTH_W;
  assign prot_viol    = write_q && !prot_q[0] && ({1'b0, widx} >= PROT_W);
  assign err          = out_of_range || misalign || prot_viol;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          latch_en = 1'b1;
          cnt_d    = WS_LOAD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (!penable) begin
          latch_en = 1'b1;
          cnt_d    = WS_LOAD;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response outputs; read data is only driven in the completing cycle of a read
  always_comb begin
    complete = (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);
    pready   = complete;
    pslverr  = complete && err;
    prdata   = '0;
    if (complete && !write_q) begin
      prdata = err ? ERR_D : mem[midx];
    end
  end

  // Setup-phase capture; later bus changes are ignored until the next setup
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= 3'd0;
    end else if (latch_en) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      prot_q  <= pprot;
    end
  end

  // Storage: reset clears every word, errored writes are dropped
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (complete && write_q && !err) begin
      for (int l = 0; l < int'(NB); l++) begin
        if (strb_q[l]) begin
          mem[midx][8*l +: 8] <= wdata_q[8*l +: 8];
        end
      end
    end
  end

  // Saturating count of errored completions
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_cnt <= 8'd0;
    end else if (complete && err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb4_ram_ws.sv
// Bench for apb4_ram_ws: a 2-wait-state instance with a protected region and a zero-wait
// instance share one APB bus (separate psel), checked against an array-based model.
module tb_apb4_ram_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel_a, psel_b, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic [7:0]  ec_a, ec_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_ram_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2), .PROT_BASE(24)) dut_ws2 (
    .pclk(clk), .presetn(rst_n), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a), .err_cnt(ec_a));

  apb4_ram_ws #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) dut_ws0 (
    .pclk(clk), .presetn(rst_n), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b), .err_cnt(ec_b));

  // Reference state: index 0 = 2-wait instance, index 1 = zero-wait instance
  logic [31:0] ref_mem [2][32];
  int          ref_cnt [2];
  int          ws_of   [2] = '{2, 0};
  int          pb_of   [2] = '{24, 32};

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? pready_a : pready_b;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ref_cnt[d] = 0;
      for (int w = 0; w < 32; w++) ref_mem[d][w] = '0;
    end
  endtask

  // Expected response from the rules: decode, error classes, lane merge, saturating count
  task automatic model(input int d, input logic [7:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr,
                       output logic [31:0] rd, output logic se);
    int  widx;
    bit  e;
    widx = int'(a) / 4;
    e = (widx >= 32) || (a[1:0] != 2'b00) || (wr && !pr[0] && widx >= pb_of[d]);
    rd = '0;
    se = e;
    if (e) begin
      if (ref_cnt[d] < 255) ref_cnt[d]++;
      if (!wr) rd = 32'hDEAD_BEEF;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) ref_mem[d][widx][8*b +: 8] = wd[8*b +: 8];
    end else begin
      rd = ref_mem[d][widx];
    end
  endtask

  // One full APB transfer; returns response, access-cycle count, completion cycle, err_cnt after
  task automatic xfer(input int d, input logic [7:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input bit perturb,
                      output logic [31:0] rd, output logic se, output int acc, output int at,
                      output logic [7:0] ec);
    bit got;
    @(negedge clk);
    psel_a = (d == 0); psel_b = (d == 1); penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
    rd = '0; se = 1'b0; acc = 0; at = 0; got = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    while (!got && acc < 20) begin
      #1;
      acc++;
      if (rdy(d)) begin
        got = 1'b1;
        rd  = (d == 0) ? prdata_a : prdata_b;
        se  = (d == 0) ? pslverr_a : pslverr_b;
        at  = cyc;
      end else begin
        if (perturb) begin
          paddr = 8'($urandom); pwdata = $urandom; pwrite = ~wr;
        end
        @(negedge clk);
      end
    end
    check("pready_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    ec = (d == 0) ? ec_a : ec_b;
  endtask

  task automatic run_chk(input string name, input int d, input logic [7:0] a, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                         input bit pt, output logic [31:0] rd, output int at);
    logic [31:0] er;
    logic        es, se;
    int          acc;
    logic [7:0]  ec;
    model(d, a, wr, wd, st, pr, er, es);
    xfer(d, a, wr, wd, st, pr, pt, rd, se, acc, at, ec);
    check({name, "_rdata"}, rd, er);
    check({name, "_slverr"}, 32'(se), 32'(es));
    check({name, "_errcnt"}, 32'(ec), 32'(ref_cnt[d]));
    check({name, "_latency"}, 32'(acc), 32'(ws_of[d] + 1));
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, er;
    logic        se, es;
    int          acc, at, prev_at;
    logic [7:0]  ec, cnt_before;

    vecs[0]  = '{8'h08, 1'b1, 32'h1122_3344, 4'hF, 3'b001, 32'h0,         1'b0, 8'd0};
    vecs[1]  = '{8'h08, 1'b1, 32'hAABB_CCDD, 4'h5, 3'b001, 32'h0,         1'b0, 8'd0};
    vecs[2]  = '{8'h08, 1'b0, 32'h0,         4'h0, 3'b000, 32'h11BB_33DD, 1'b0, 8'd0};
    vecs[3]  = '{8'h60, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0,         1'b1, 8'd1};
    vecs[4]  = '{8'h60, 1'b0, 32'h0,         4'h0, 3'b000, 32'h0,         1'b0, 8'd1};
    vecs[5]  = '{8'h60, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0,         1'b0, 8'd1};
    vecs[6]  = '{8'h60, 1'b0, 32'h0,         4'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 8'd1};
    vecs[7]  = '{8'h80, 1'b0, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 1'b1, 8'd2};
    vecs[8]  = '{8'h05, 1'b1, 32'h1234_5678, 4'hF, 3'b001, 32'h0,         1'b1, 8'd3};
    vecs[9]  = '{8'h04, 1'b0, 32'h0,         4'h0, 3'b000, 32'h0,         1'b0, 8'd3};
    vecs[10] = '{8'h0C, 1'b1, 32'h0000_0055, 4'h0, 3'b001, 32'h0,         1'b0, 8'd3};
    vecs[11] = '{8'h0C, 1'b0, 32'h0,         4'h0, 3'b000, 32'h0,         1'b0, 8'd3};

    rst_n = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_pready", 32'(pready_a), 32'd0);
    check("rst_pslverr", 32'(pslverr_a), 32'd0);
    check("rst_prdata", prdata_a, 32'd0);
    check("rst_errcnt", 32'(ec_a), 32'd0);
    check("rst_pready_b", 32'(pready_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, issued back to back
    for (int i = 0; i < 12; i++) begin
      model(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, er, es);
      xfer(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, 1'b0,
           rd, se, acc, at, ec);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_slverr", i), 32'(se), 32'(vecs[i].err));
      check($sformatf("vec%0d_errcnt", i), 32'(ec), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_latency", i), 32'(acc), 32'd3);
    end
    bus_idle();

    // Abort after one wait cycle leaves memory and count alone
    run_chk("pre_abort", 0, 8'h10, 1'b1, 32'h0102_0304, 4'hF, 3'b001, 1'b0, rd, at);
    cnt_before = ec_a;
    @(negedge clk);
    psel_a = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b1;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_errcnt", 32'(ec_a), 32'(cnt_before));
    run_chk("abort_read", 0, 8'h10, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, at);
    check("abort_mem", rd, 32'h0102_0304);

    // Bus wiggles during wait cycles are ignored
    run_chk("wiggle_wr", 0, 8'h14, 1'b1, 32'h0000_0077, 4'hF, 3'b001, 1'b1, rd, at);
    run_chk("wiggle_rd", 0, 8'h14, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, at);
    check("wiggle_mem", rd, 32'h0000_0077);
    bus_idle();

    // Zero-wait instance: back-to-back writes complete every second cycle
    prev_at = 0;
    for (int k = 0; k < 4; k++) begin
      run_chk("ws0_wr", 1, 8'(4 * k), 1'b1, 32'(k + 1), 4'hF, 3'b000, 1'b0, rd, at);
      if (k > 0) check("ws0_spacing", 32'(at - prev_at), 32'd2);
      prev_at = at;
    end
    for (int k = 0; k < 4; k++) begin
      run_chk("ws0_rd", 1, 8'(4 * k), 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, at);
      check("ws0_readback", rd, 32'(k + 1));
      check("ws0_rd_spacing", 32'(at - prev_at), 32'd2);
      prev_at = at;
    end
    bus_idle();

    // Randomized traffic on both instances against the model
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 8'h8F));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_chk("rand", n % 2, a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
              1'($urandom), rd, at);
    end
    bus_idle();

    // Count saturation
    for (int n = 0; n < 260; n++)
      run_chk("sat", 0, 8'h80, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, at);
    check("sat_errcnt", 32'(ec_a), 32'd255);

    // Reset in the middle of a transfer
    @(negedge clk);
    psel_a = 1'b1; psel_b = 1'b0; penable = 1'b0; paddr = 8'h08; pwrite = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_errcnt", 32'(ec_a), 32'd0);
    check("midrst_pready", 32'(pready_a), 32'd0);
    check("midrst_prdata", prdata_a, 32'd0);
    check("midrst_pslverr", 32'(pslverr_a), 32'd0);
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int w = 0; w < 32; w++) begin
      run_chk("clr_a", 0, 8'(4 * w), 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, at);
      check("clr_a_zero", rd, 32'd0);
    end
    for (int w = 0; w < 4; w++) begin
      run_chk("clr_b", 1, 8'(4 * w), 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, rd, at);
      check("clr_b_zero", rd, 32'd0);
    end
    bus_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
